// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Combinational helpers only; no latency and no backpressure.
// Used by lsu_ctrl and lsu_load_extract.
package lsu_pkg;

    localparam int MEM_AW = 16;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HI   = 1'b1
    } state_e;

    // Unsigned loads have no store counterpart, so BU/HU stores fall back to W.
    function automatic funct3_e norm_funct3(input logic [2:0] f3, input logic we);
        case (f3)
            3'b000:  return F3_B;
            3'b001:  return F3_H;
            3'b100:  return we ? F3_W : F3_BU;
            3'b101:  return we ? F3_W : F3_HU;
            default: return F3_W;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input funct3_e f3);
        case (f3)
            F3_B, F3_BU: return 3'd1;
            F3_H, F3_HU: return 3'd2;
            default:     return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input funct3_e f3);
        case (f3)
            F3_B, F3_BU: return 4'b0001;
            F3_H, F3_HU: return 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    function automatic logic is_cross(input logic [1:0] off, input funct3_e f3);
        return ({1'b0, off} + size_bytes(f3)) > 3'd4;
    endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Aligns a {hi,lo} memory pair by byte offset and sign/zero-extends the load.
// Purely combinational; no backpressure.
// Upper bytes of the shifted pair are discarded by design.
module lsu_load_extract
    import lsu_pkg::*;
(
    input  logic [63:0] data,
    input  logic [1:0]  off,
    input  funct3_e     funct3,
    output logic [31:0] result
);

    logic [63:0] shifted;
    logic        unused_upper;

    assign shifted      = data >> {off, 3'b000};
    assign unused_upper = ^shifted[63:32];

    always_comb begin
        result = shifted[31:0];
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'h0, shifted[7:0]};
            F3_HU:   result = {16'h0, shifted[15:0]};
            default: result = shifted[31:0];
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store control to a 16-bit synchronous-read data memory; LSU_MISALIGN_EN splits word-crossing accesses.
// Latency: load data one cycle after the final memory access (two cycles for a split load).
// Backpressure: o_stall holds MEM for the lo half of a split access only; aligned traffic never stalls.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_stall,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    output logic              o_mem_wren,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_ld_valid,
    output logic [31:0]       o_ld_data,
    output logic              o_misalign
);

    funct3_e           req_f3;
    logic [1:0]        req_off;
    logic [MEM_AW-3:0] req_word;
    logic [7:0]        req_mask8;
    logic [63:0]       req_data64;
    logic              req_cross;
    logic              unused_addr_hi;

    assign req_f3         = norm_funct3(i_req_funct3, i_req_we);
    assign req_off        = i_req_addr[1:0];
    assign req_word       = i_req_addr[MEM_AW-1:2];
    assign req_mask8      = {4'b0000, size_mask(req_f3)} << req_off;
    assign req_data64     = {32'h0, i_req_wdata} << {req_off, 3'b000};
    assign req_cross      = is_cross(req_off, req_f3);
    assign unused_addr_hi = ^i_req_addr[31:MEM_AW];

    logic        trk_pend_q;
    funct3_e     trk_f3_q;
    logic [1:0]  trk_off_q;
    logic [31:0] ld_lo;
    logic [31:0] ld_result;

    lsu_load_extract u_extract (
        .data   ({i_mem_rdata, ld_lo}),
        .off    (trk_off_q),
        .funct3 (trk_f3_q),
        .result (ld_result)
    );

    assign o_ld_valid = trk_pend_q;

`ifdef LSU_MISALIGN_EN
    state_e            state_q;
    state_e            state_d;
    logic [MEM_AW-3:0] hi_word_q;
    logic [3:0]        hi_bmask_q;
    logic [31:0]       hi_wdata_q;
    logic              hi_we_q;
    funct3_e           hi_f3_q;
    logic [1:0]        hi_off_q;
    logic [31:0]       hold_q;
    logic              trk_split_q;

    assign o_misalign = 1'b0;
    assign ld_lo      = trk_split_q ? hold_q : i_mem_rdata;
    assign o_ld_data  = ld_result;

    always_comb begin
        state_d     = state_q;
        o_mem_addr  = {req_word, 2'b00};
        o_mem_bmask = req_mask8[3:0];
        o_mem_wdata = req_data64[31:0];
        o_mem_wren  = i_req_valid & i_req_we;
        o_stall     = 1'b0;
        if (state_q == ST_HI) begin
            o_mem_addr  = {hi_word_q, 2'b00};
            o_mem_bmask = hi_bmask_q;
            o_mem_wdata = hi_wdata_q;
            o_mem_wren  = hi_we_q;
            state_d     = ST_IDLE;
        end else if (i_req_valid && req_cross) begin
            o_stall = 1'b1;
            state_d = ST_HI;
        end
        if (i_reset) begin
            o_mem_wren = 1'b0;
            o_stall    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            hi_word_q   <= '0;
            hi_bmask_q  <= '0;
            hi_wdata_q  <= '0;
            hi_we_q     <= 1'b0;
            hi_f3_q     <= F3_B;
            hi_off_q    <= '0;
            hold_q      <= '0;
            trk_pend_q  <= 1'b0;
            trk_f3_q    <= F3_B;
            trk_off_q   <= '0;
            trk_split_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trk_pend_q <= 1'b0;
            if (state_q == ST_HI) begin
                // lo-word read data arrives during the HI cycle
                hold_q      <= i_mem_rdata;
                trk_pend_q  <= ~hi_we_q;
                trk_f3_q    <= hi_f3_q;
                trk_off_q   <= hi_off_q;
                trk_split_q <= 1'b1;
            end else if (i_req_valid) begin
                if (req_cross) begin
                    hi_word_q  <= req_word + 1'b1;
                    hi_bmask_q <= req_mask8[7:4];
                    hi_wdata_q <= req_data64[63:32];
                    hi_we_q    <= i_req_we;
                    hi_f3_q    <= req_f3;
                    hi_off_q   <= req_off;
                end else begin
                    trk_pend_q  <= ~i_req_we;
                    trk_f3_q    <= req_f3;
                    trk_off_q   <= req_off;
                    trk_split_q <= 1'b0;
                end
            end
        end
    end
`else
    logic trk_zero_q;
    logic unused_hi_half;

    assign unused_hi_half = ^{req_mask8[7:4], req_data64[63:32]};
    assign ld_lo          = i_mem_rdata;
    assign o_ld_data      = trk_zero_q ? 32'h0 : ld_result;

    always_comb begin
        o_mem_addr  = {req_word, 2'b00};
        o_mem_bmask = req_mask8[3:0];
        o_mem_wdata = req_data64[31:0];
        o_mem_wren  = i_req_valid & i_req_we & ~req_cross & ~i_reset;
        o_misalign  = i_req_valid & req_cross & ~i_reset;
        o_stall     = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            trk_pend_q <= 1'b0;
            trk_f3_q   <= F3_B;
            trk_off_q  <= '0;
            trk_zero_q <= 1'b0;
        end else begin
            trk_pend_q <= i_req_valid & ~i_req_we;
            if (i_req_valid && !i_req_we) begin
                trk_f3_q   <= req_f3;
                trk_off_q  <= req_off;
                trk_zero_q <= req_cross;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a synchronous-read byte-lane memory model.
// Follows LSU_MISALIGN_EN to pick the split-access or rejection scenarios.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_wren;
    bit   [31:0] mem_rdata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req_valid  (req_valid),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_stall      (stall),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_bmask  (mem_bmask),
        .o_mem_wren   (mem_wren),
        .i_mem_rdata  (mem_rdata),
        .o_ld_valid   (ld_valid),
        .o_ld_data    (ld_data),
        .o_misalign   (misalign)
    );

    bit   [31:0] mem [0:16383];
    logic [31:0] lane_m;
    assign lane_m = {{8{mem_bmask[3]}}, {8{mem_bmask[2]}}, {8{mem_bmask[1]}}, {8{mem_bmask[0]}}};

    always @(posedge clk) begin
        if (mem_wren === 1'b1) begin
            mem[mem_addr[15:2]] <= (mem[mem_addr[15:2]] & ~lane_m) | (mem_wdata & lane_m);
            mem_rdata <= '0;
        end else begin
            mem_rdata <= mem[mem_addr[15:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        req_valid  = v;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h1234_5678);
        tick();
        tick();
        check("rst_wren", mem_wren, 0);
        check("rst_stall", stall, 0);
        check("rst_ld_valid", ld_valid, 0);
        check("rst_misalign", misalign, 0);
        rst = 1'b0;

        // SW 0xDEADBEEF -> 0x0100, then LW
        req(1'b1, 1'b1, 3'b010, 32'hFFFF_0100, 32'hDEAD_BEEF);
        check("sw_addr", mem_addr, 32'h0100);
        check("sw_bmask", mem_bmask, 4'b1111);
        check("sw_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("sw_wren", mem_wren, 1);
        tick();
        req(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        check("lw_wren", mem_wren, 0);
        check("lw_stall", stall, 0);
        check("lw_ld_valid_early", ld_valid, 0);
        tick();
        req(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        check("lw_ld_valid", ld_valid, 1);
        check("lw_data", ld_data, 32'hDEAD_BEEF);
        tick();
        check("lw_valid_one_cycle", ld_valid, 0);

        // SB 0xA5 -> 0x0103, then LB and LBU back-to-back
        req(1'b1, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
        check("sb_bmask", mem_bmask, 4'b1000);
        check("sb_wdata", mem_wdata, 32'hA500_0000);
        check("sb_addr", mem_addr, 32'h0100);
        tick();
        req(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
        tick();
        req(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0);
        check("lb_valid", ld_valid, 1);
        check("lb_data", ld_data, 32'hFFFF_FFA5);
        tick();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("lbu_valid", ld_valid, 1);
        check("lbu_data", ld_data, 32'h0000_00A5);
        tick();

        // SH 0x8001 -> 0x0101 stays in one word on lanes 1..2
        req(1'b1, 1'b1, 3'b001, 32'h0000_0101, 32'h0000_8001);
        check("sh_bmask", mem_bmask, 4'b0110);
        check("sh_wdata", mem_wdata, 32'h0080_0100);
        check("sh_stall", stall, 0);
        check("sh_misalign", misalign, 0);
        tick();
        req(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0);
        tick();
        req(1'b1, 1'b0, 3'b101, 32'h0000_0101, 32'h0);
        check("lh_data", ld_data, 32'hFFFF_8001);
        tick();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("lhu_data", ld_data, 32'h0000_8001);
        tick();

        // invalid funct3 codes behave as W (store 011, load 111)
        req(1'b1, 1'b1, 3'b011, 32'h0000_0300, 32'h1234_5678);
        check("inv_st_bmask", mem_bmask, 4'b1111);
        tick();
        req(1'b1, 1'b1, 3'b100, 32'h0000_0300, 32'h0000_00EE);
        check("sbu_as_w_bmask", mem_bmask, 4'b1111);
        req(1'b1, 1'b1, 3'b011, 32'h0000_0300, 32'h1234_5678);
        tick();
        req(1'b1, 1'b0, 3'b111, 32'h0000_0300, 32'h0);
        tick();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("inv_ld_data", ld_data, 32'h1234_5678);
        tick();

`ifdef LSU_MISALIGN_EN
        // SW 0x11223344 -> 0x0203 splits across words 0x80 / 0x81
        req(1'b1, 1'b1, 3'b010, 32'h0000_0203, 32'h1122_3344);
        check("ssw_lo_stall", stall, 1);
        check("ssw_lo_addr", mem_addr, 32'h0200);
        check("ssw_lo_bmask", mem_bmask, 4'b1000);
        check("ssw_lo_wdata", mem_wdata, 32'h4400_0000);
        tick();
        check("ssw_hi_stall", stall, 0);
        check("ssw_hi_addr", mem_addr, 32'h0204);
        check("ssw_hi_bmask", mem_bmask, 4'b0111);
        check("ssw_hi_wdata", mem_wdata, 32'h0011_2233);
        check("ssw_hi_wren", mem_wren, 1);
        tick();
        req(1'b1, 1'b0, 3'b010, 32'h0000_0203, 32'h0);
        check("slw_lo_stall", stall, 1);
        tick();
        check("slw_hi_addr", mem_addr, 32'h0204);
        check("slw_hi_valid", ld_valid, 0);
        tick();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("slw_valid", ld_valid, 1);
        check("slw_data", ld_data, 32'h1122_3344);
        tick();

        // LH at 0xFFFF wraps to word 0; reset in the HI cycle aborts it
        req(1'b1, 1'b0, 3'b001, 32'h0000_FFFF, 32'h0);
        check("wrap_lo_addr", mem_addr, 32'hFFFC);
        check("wrap_lo_bmask", mem_bmask, 4'b1000);
        tick();
        check("wrap_hi_addr", mem_addr, 32'h0000);
        check("wrap_hi_bmask", mem_bmask, 4'b0001);
        rst = 1'b1;
        #1;
        check("wrap_rst_stall", stall, 0);
        tick();
        rst = 1'b0;
        req(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
        check("wrap_no_ld_valid", ld_valid, 0);
        check("wrap_idle_stall", stall, 0);
        check("wrap_idle_addr", mem_addr, 32'h0100);
        tick();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
`else
        // crossing accesses are rejected without touching memory
        req(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'hCAFE_F00D);
        tick();
        req(1'b1, 1'b0, 3'b010, 32'h0000_0001, 32'h0);
        check("mis_lw_flag", misalign, 1);
        check("mis_lw_wren", mem_wren, 0);
        check("mis_lw_stall", stall, 0);
        tick();
        req(1'b1, 1'b1, 3'b010, 32'h0000_0002, 32'h5555_AAAA);
        check("mis_lw_valid", ld_valid, 1);
        check("mis_lw_data", ld_data, 32'h0);
        check("mis_sw_flag", misalign, 1);
        check("mis_sw_wren", mem_wren, 0);
        tick();
        req(1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0);
        check("mis_sw_no_valid", ld_valid, 0);
        check("lh_off2_no_flag", misalign, 0);
        tick();
        req(1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0);
        check("lh_off2_data", ld_data, 32'hFFFF_CAFE);
        check("mis_lh_flag", misalign, 1);
        tick();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("mis_lh_data", ld_data, 32'h0);
        check("mis_lh_flag_clear", misalign, 0);
        tick();
        req(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0);
        tick();
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        check("mis_word_intact", ld_data, 32'hCAFE_F00D);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
